// File: rtl/core_rvfi_retire_seq.sv
// In-order retirement sequencer feeding the RVFI trace port.
// Retired records wait in a small circular buffer until their memory response
// (if any) has been merged in. They then leave one per cycle, in program order,
// each tagged with a running 64-bit order number.
module core_rvfi_retire_seq #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [ILEN-1:0]     r_insn,
  input  logic                r_trap,
  input  logic [XLEN-1:0]     r_pc_rdata,
  input  logic [XLEN-1:0]     r_pc_wdata,
  input  logic [4:0]          r_rd_addr,
  input  logic [XLEN-1:0]     r_rd_wdata,
  input  logic                r_mem_load,
  input  logic                r_mem_store,
  input  logic [XLEN-1:0]     r_mem_addr,
  input  logic [XLEN/8-1:0]   r_mem_mask,
  input  logic [XLEN-1:0]     r_mem_wdata,
  input  logic                m_rsp_valid,
  input  logic [XLEN-1:0]     m_rsp_rdata,
  input  logic                m_rsp_error,
  output logic                o_valid,
  output logic [63:0]         o_order,
  output logic [ILEN-1:0]     o_insn,
  output logic                o_trap,
  output logic [XLEN-1:0]     o_pc_rdata,
  output logic [XLEN-1:0]     o_pc_wdata,
  output logic [4:0]          o_rd_addr,
  output logic [XLEN-1:0]     o_rd_wdata,
  output logic [XLEN-1:0]     o_mem_addr,
  output logic [XLEN/8-1:0]   o_mem_rmask,
  output logic [XLEN/8-1:0]   o_mem_wmask,
  output logic [XLEN-1:0]     o_mem_rdata,
  output logic [XLEN-1:0]     o_mem_wdata,
  output logic                o_seq_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int MW = XLEN / 8;
  localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

  // Buffer entry storage (one slot per array index).
  logic [ILEN-1:0]  e_insn_r      [DEPTH];
  logic             e_trap_r      [DEPTH];
  logic [XLEN-1:0]  e_pc_rdata_r  [DEPTH];
  logic [XLEN-1:0]  e_pc_wdata_r  [DEPTH];
  logic [4:0]       e_rd_addr_r   [DEPTH];
  logic [XLEN-1:0]  e_rd_wdata_r  [DEPTH];
  logic             e_load_r      [DEPTH];
  logic [XLEN-1:0]  e_mem_addr_r  [DEPTH];
  logic [MW-1:0]    e_mem_rmask_r [DEPTH];
  logic [MW-1:0]    e_mem_wmask_r [DEPTH];
  logic [XLEN-1:0]  e_mem_rdata_r [DEPTH];
  logic [XLEN-1:0]  e_mem_wdata_r [DEPTH];
  logic [DEPTH-1:0] pend_r;

  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [PW:0]      count_r;
  logic [63:0]      order_cnt_r;
  logic             seq_err_r;

  logic             enq_s;
  logic             deq_s;
  logic             is_mem_s;
  logic             rsp_hit_s;
  logic [PW-1:0]    rsp_idx_s;
  logic [PW-1:0]    scan_idx_s;

  // Ready derives from the registered count only, so a full buffer refuses
  // a retire even in the cycle it drains an entry.
  assign r_ready  = (count_r != FULL_C);
  assign enq_s    = r_valid && r_ready;
  assign deq_s    = (count_r != '0) && !pend_r[head_r];
  assign is_mem_s = r_mem_load || r_mem_store;
  assign o_seq_err = seq_err_r;

  // Find the oldest pending entry: scan from youngest to oldest relative to
  // head so the slot closest to head wins. Free slots never have pend set.
  always_comb begin
    rsp_hit_s  = |pend_r;
    rsp_idx_s  = head_r;
    scan_idx_s = head_r;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan_idx_s = head_r + PW'(i);
      rsp_idx_s  = pend_r[scan_idx_s] ? scan_idx_s : rsp_idx_s;
    end
  end

  // Pointers, occupancy, order counter and sticky sequencing error.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      order_cnt_r <= 64'd0;
      seq_err_r   <= 1'b0;
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (deq_s) begin
        head_r      <= head_r + PW'(1);
        order_cnt_r <= order_cnt_r + 64'd1;
      end
      if (enq_s && !deq_s) begin
        count_r <= count_r + (PW+1)'(1);
      end else if (!enq_s && deq_s) begin
        count_r <= count_r - (PW+1)'(1);
      end
      if (m_rsp_valid && !rsp_hit_s) begin
        seq_err_r <= 1'b1;
      end
    end
  end

  // Outstanding-response flags: set on memory-op enqueue, cleared by the
  // matching response; reset flushes every entry.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      pend_r <= '0;
    end else begin
      if (enq_s) begin
        pend_r[tail_r] <= is_mem_s;
      end
      if (m_rsp_valid && rsp_hit_s) begin
        pend_r[rsp_idx_s] <= 1'b0;
      end
    end
  end

  // Entry payload: capture at enqueue, merge load data / fault on response.
  // An enqueue and a response never target the same slot in one cycle.
  always_ff @(posedge g_clk) begin
    if (enq_s) begin
      e_insn_r[tail_r]      <= r_insn;
      e_trap_r[tail_r]      <= r_trap;
      e_pc_rdata_r[tail_r]  <= r_pc_rdata;
      e_pc_wdata_r[tail_r]  <= r_pc_wdata;
      e_rd_addr_r[tail_r]   <= r_rd_addr;
      e_rd_wdata_r[tail_r]  <= (r_rd_addr == 5'd0 || r_mem_load) ? '0 : r_rd_wdata;
      e_load_r[tail_r]      <= r_mem_load;
      e_mem_addr_r[tail_r]  <= is_mem_s ? r_mem_addr : '0;
      e_mem_rmask_r[tail_r] <= r_mem_load ? r_mem_mask : '0;
      e_mem_wmask_r[tail_r] <= r_mem_store ? r_mem_mask : '0;
      e_mem_rdata_r[tail_r] <= '0;
      e_mem_wdata_r[tail_r] <= is_mem_s ? r_mem_wdata : '0;
    end
    if (m_rsp_valid && rsp_hit_s) begin
      if (e_load_r[rsp_idx_s]) begin
        e_mem_rdata_r[rsp_idx_s] <= m_rsp_rdata;
        e_rd_wdata_r[rsp_idx_s]  <= (m_rsp_error || e_rd_addr_r[rsp_idx_s] == 5'd0) ?
                                    '0 : m_rsp_rdata;
      end else begin
        e_mem_rdata_r[rsp_idx_s] <= '0;
        if (m_rsp_error) begin
          e_rd_wdata_r[rsp_idx_s] <= '0;
        end
      end
      if (m_rsp_error) begin
        e_trap_r[rsp_idx_s] <= 1'b1;
      end
    end
  end

  // Trace output registers: load the head record on dequeue, hold otherwise.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      o_valid     <= 1'b0;
      o_order     <= 64'd0;
      o_insn      <= '0;
      o_trap      <= 1'b0;
      o_pc_rdata  <= '0;
      o_pc_wdata  <= '0;
      o_rd_addr   <= 5'd0;
      o_rd_wdata  <= '0;
      o_mem_addr  <= '0;
      o_mem_rmask <= '0;
      o_mem_wmask <= '0;
      o_mem_rdata <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_valid <= deq_s;
      if (deq_s) begin
        o_order     <= order_cnt_r;
        o_insn      <= e_insn_r[head_r];
        o_trap      <= e_trap_r[head_r];
        o_pc_rdata  <= e_pc_rdata_r[head_r];
        o_pc_wdata  <= e_pc_wdata_r[head_r];
        o_rd_addr   <= e_rd_addr_r[head_r];
        o_rd_wdata  <= e_rd_wdata_r[head_r];
        o_mem_addr  <= e_mem_addr_r[head_r];
        o_mem_rmask <= e_mem_rmask_r[head_r];
        o_mem_wmask <= e_mem_wmask_r[head_r];
        o_mem_rdata <= e_mem_rdata_r[head_r];
        o_mem_wdata <= e_mem_wdata_r[head_r];
      end
    end
  end

endmodule
